// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: decodeop, memtoreg and the squash FSM state.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int XLEN     = 32;
  localparam int REG_W    = 5;
  // Squash counter width; wide enough for SQUASH_CYCLES in 1..7.
  localparam int SQ_CNT_W = 3;

  typedef enum logic [1:0] {
    DEC_NONE = 2'b00,
    DEC_BEQ  = 2'b01,
    DEC_BNE  = 2'b10,
    DEC_JR   = 2'b11
  } decodeop_e;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10
  } memtoreg_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } squash_state_e;

  // Branch condition for a decode op, ignoring validity and squash state.
  function automatic logic branch_cond(input decodeop_e op, input logic zero);
    logic cond;
    cond = 1'b0;
    case (op)
      DEC_BEQ: cond = zero;
      DEC_BNE: cond = !zero;
      DEC_JR:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/redirect_ctrl.sv
// Branch/jr resolution, one-cycle redirect pulse and upstream squash sequencer.
// Latency: redirect and flush_upstream assert 1 cycle after a taken bundle is captured.
// Backpressure: nothing is captured while stalled; stall freezes the squash counter.
module redirect_ctrl
  import pipeline_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            zero,
  input  logic [1:0]      decodeop,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jr_target,
  output logic            squashing,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_upstream
);

  localparam logic [SQ_CNT_W-1:0] SQ_LOAD = SQ_CNT_W'(SQUASH_CYCLES);

  squash_state_e       state_q, state_d;
  logic [SQ_CNT_W-1:0] cnt_q, cnt_d;
  logic                redirect_q, redirect_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
  logic                taken;
  logic                capture_taken;

  assign squashing      = (state_q == SQUASH);
  assign flush_upstream = squashing;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;

  // Resolve the incoming bundle; wrong-path bundles during SQUASH never redirect.
  always_comb begin
    taken         = ex_valid && !squashing && branch_cond(decodeop_e'(decodeop), zero);
    capture_taken = load_en && taken;
  end

  // Squash FSM: enter on the same edge that captures the taken bundle so the
  // very next bundle is already dropped; count down only on non-stalled cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (capture_taken) begin
          state_d = SQUASH;
          cnt_d   = SQ_LOAD;
        end
      end
      SQUASH: begin
        if (!stall) begin
          if (cnt_q == SQ_CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - SQ_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Redirect pulse lasts exactly one cycle; target holds until the next redirect.
  always_comb begin
    redirect_d    = capture_taken;
    redirect_pc_d = redirect_pc_q;
    if (capture_taken) begin
      redirect_pc_d = (decodeop_e'(decodeop) == DEC_JR) ? jr_target : branch_target;
    end
  end

  // State register; reset aborts any squash in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary register with branch/jr redirect and upstream squash (optional perf counters: EX_MEM_PERF_CNT_EN).
// Latency: 1 cycle input to mem_* outputs; redirect 1 cycle after capture.
// Backpressure: stall holds every register; flush (higher priority) inserts a bubble.
module ex_mem_stage
  import pipeline_pkg::*;
#(
  parameter int              SQUASH_CYCLES = 2,
  parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ALU_result,
  input  logic              Zero,
  input  logic [REG_W-1:0]  regdst,
  input  logic [XLEN-1:0]   reg_data2,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   BranchTarget,
  input  logic [XLEN-1:0]   JumpRegisterTarget,
  input  logic              regwrite,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [1:0]        memtoreg,
  input  logic [1:0]        decodeop,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_alu_result,
  output logic [XLEN-1:0]   mem_store_data,
  output logic [XLEN-1:0]   mem_pc,
  output logic [REG_W-1:0]  mem_regdst,
  output logic              mem_regwrite,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [1:0]        mem_memtoreg,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              flush_upstream
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]       redirect_count,
  output logic [31:0]       bubble_count
`endif
);

  logic             load_en;
  logic             squashing;

  logic             mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]  mem_alu_result_q, mem_alu_result_d;
  logic [XLEN-1:0]  mem_store_data_q, mem_store_data_d;
  logic [XLEN-1:0]  mem_pc_q, mem_pc_d;
  logic [REG_W-1:0] mem_regdst_q, mem_regdst_d;
  logic             mem_regwrite_q, mem_regwrite_d;
  logic             mem_memwrite_q, mem_memwrite_d;
  logic             mem_memread_q, mem_memread_d;
  logic [1:0]       mem_memtoreg_q, mem_memtoreg_d;

  assign load_en = !flush && !stall;

  // Capture priority flush > stall > load; flush clears only the valid bit.
  always_comb begin
    mem_valid_d      = mem_valid_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_pc_d         = mem_pc_q;
    mem_regdst_d     = mem_regdst_q;
    mem_regwrite_d   = mem_regwrite_q;
    mem_memwrite_d   = mem_memwrite_q;
    mem_memread_d    = mem_memread_q;
    mem_memtoreg_d   = mem_memtoreg_q;
    if (flush) begin
      mem_valid_d = 1'b0;
    end else if (!stall) begin
      mem_valid_d      = ex_valid && !squashing;
      mem_alu_result_d = ALU_result;
      mem_store_data_d = reg_data2;
      mem_pc_d         = pc;
      mem_regdst_d     = regdst;
      mem_regwrite_d   = regwrite;
      mem_memwrite_d   = memwrite;
      mem_memread_d    = memread;
      mem_memtoreg_d   = memtoreg;
    end
  end

  // Boundary registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_valid_q      <= 1'b0;
      mem_alu_result_q <= '0;
      mem_store_data_q <= '0;
      mem_pc_q         <= RESET_PC;
      mem_regdst_q     <= '0;
      mem_regwrite_q   <= 1'b0;
      mem_memwrite_q   <= 1'b0;
      mem_memread_q    <= 1'b0;
      mem_memtoreg_q   <= '0;
    end else begin
      mem_valid_q      <= mem_valid_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_pc_q         <= mem_pc_d;
      mem_regdst_q     <= mem_regdst_d;
      mem_regwrite_q   <= mem_regwrite_d;
      mem_memwrite_q   <= mem_memwrite_d;
      mem_memread_q    <= mem_memread_d;
      mem_memtoreg_q   <= mem_memtoreg_d;
    end
  end

  // Side-effecting controls are gated so an invalid slot can never write.
  assign mem_valid      = mem_valid_q;
  assign mem_alu_result = mem_alu_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_pc         = mem_pc_q;
  assign mem_regdst     = mem_regdst_q;
  assign mem_regwrite   = mem_regwrite_q && mem_valid_q;
  assign mem_memwrite   = mem_memwrite_q && mem_valid_q;
  assign mem_memread    = mem_memread_q && mem_valid_q;
  assign mem_memtoreg   = mem_memtoreg_q;

  redirect_ctrl #(
    .SQUASH_CYCLES (SQUASH_CYCLES)
  ) u_redirect_ctrl (
    .clk            (Clk),
    .rst_n          (Rst_n),
    .load_en        (load_en),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .zero           (Zero),
    .decodeop       (decodeop),
    .branch_target  (BranchTarget),
    .jr_target      (JumpRegisterTarget),
    .squashing      (squashing),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush_upstream (flush_upstream)
  );

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] redirect_count_q, redirect_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  // Count redirect pulses and loads that produced a bubble; both wrap freely.
  always_comb begin
    redirect_count_d = redirect_count_q + {31'd0, redirect};
    bubble_count_d   = bubble_count_q + {31'd0, (load_en && !mem_valid_d)};
  end

  // Counter registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      redirect_count_q <= '0;
      bubble_count_q   <= '0;
    end else begin
      redirect_count_q <= redirect_count_d;
      bubble_count_q   <= bubble_count_d;
    end
  end

  assign redirect_count = redirect_count_q;
  assign bubble_count   = bubble_count_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  localparam int          SQC = 2;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        Clk, Rst_n;
  logic        ex_valid, Zero, regwrite, memwrite, memread, stall, flush;
  logic [31:0] ALU_result, reg_data2, pc, BranchTarget, JumpRegisterTarget;
  logic [4:0]  regdst;
  logic [1:0]  memtoreg, decodeop;
  logic        mem_valid, mem_regwrite, mem_memwrite, mem_memread;
  logic [31:0] mem_alu_result, mem_store_data, mem_pc, redirect_pc;
  logic [4:0]  mem_regdst;
  logic [1:0]  mem_memtoreg;
  logic        redirect, flush_upstream;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        mr;
    logic [1:0]  mtr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_sq     = 0;
  logic        m_redir  = 1'b0;
  logic [31:0] m_rpc    = '0;

  ex_mem_stage #(.SQUASH_CYCLES(SQC), .RESET_PC(RPC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ex_valid(ex_valid), .ALU_result(ALU_result), .Zero(Zero),
    .regdst(regdst), .reg_data2(reg_data2), .pc(pc), .BranchTarget(BranchTarget),
    .JumpRegisterTarget(JumpRegisterTarget), .regwrite(regwrite), .memwrite(memwrite),
    .memread(memread), .memtoreg(memtoreg), .decodeop(decodeop), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_pc(mem_pc), .mem_regdst(mem_regdst), .mem_regwrite(mem_regwrite),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_memtoreg(mem_memtoreg),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush_upstream(flush_upstream)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t obs_now();
    return {mem_valid, mem_alu_result, mem_store_data, mem_pc, mem_regdst,
            mem_regwrite, mem_memwrite, mem_memread, mem_memtoreg};
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic set_bundle(input logic v, input logic [1:0] op, input logic z);
    ex_valid           = v;
    decodeop           = op;
    Zero               = z;
    ALU_result         = $urandom;
    reg_data2          = $urandom;
    pc                 = $urandom;
    BranchTarget       = $urandom;
    JumpRegisterTarget = $urandom;
    regdst             = 5'($urandom_range(0, 31));
    memtoreg           = 2'($urandom_range(0, 2));
    regwrite           = 1'($urandom_range(0, 1));
    memwrite           = 1'($urandom_range(0, 1));
    memread            = 1'($urandom_range(0, 1));
  endtask

  // One clock: push the expected capture (if any), advance, update the squash model.
  task automatic tick();
    logic        load, sq, cond, tk, st;
    logic [31:0] tgt;
    exp_t        e;
    load = !flush && !stall;
    sq   = (m_sq > 0);
    st   = stall;
    case (decodeop)
      2'b01:   cond = Zero;
      2'b10:   cond = !Zero;
      2'b11:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
    tk  = load && ex_valid && !sq && cond;
    tgt = (decodeop == 2'b11) ? JumpRegisterTarget : BranchTarget;
    if (load) begin
      e.valid = ex_valid && !sq;
      e.alu   = ALU_result;
      e.sd    = reg_data2;
      e.pc    = pc;
      e.rd    = regdst;
      e.rw    = regwrite && e.valid;
      e.mw    = memwrite && e.valid;
      e.mr    = memread && e.valid;
      e.mtr   = memtoreg;
      sb.push_back(e);
    end
    @(posedge Clk);
    #1;
    m_redir = tk;
    if (tk) m_rpc = tgt;
    if (tk) m_sq = SQC;
    else if (sq && !st) m_sq = m_sq - 1;
  endtask

  task automatic model_reset();
    m_sq = 0; m_redir = 1'b0; m_rpc = '0; sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    Rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_bundle(1'b1, 2'b11, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    e = '0; e.pc = RPC;
    n_checks++; if (obs_now() !== e) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs_now(), e); end
    n_checks++; if (redirect !== 1'b0 || flush_upstream !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_redirect got=%b/%b/%h exp=0/0/0", redirect, flush_upstream, redirect_pc); end
    model_reset();
    Rst_n = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e;
    set_bundle(1'b1, 2'b00, 1'b0);
    ALU_result = 32'h1234; regdst = 5'd8; regwrite = 1'b1;
    tick();
    e = pop_exp();
    n_checks++; if (mem_alu_result !== 32'h1234 || mem_regdst !== 5'd8 || mem_regwrite !== 1'b1 || mem_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_const got=%h/%0d/%b/%b exp=1234/8/1/1", mem_alu_result, mem_regdst, mem_regwrite, mem_valid); end
    n_checks++; if (obs_now() !== e) begin n_fail++; $display("FAIL basic_capture got=%h exp=%h", obs_now(), e); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      set_bundle((i % 3) != 2, 2'b00, 1'(i % 2));
      if ((i % 3) == 2) begin regwrite = 1'b1; memwrite = 1'b1; memread = 1'b1; end
      tick();
      e = pop_exp();
      n_checks++; if (obs_now() !== e) begin n_fail++; $display("FAIL b2b[%0d] got=%h exp=%h", i, obs_now(), e); end
      n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL b2b_redirect[%0d] got=%b exp=0", i, redirect); end
    end
  endtask

  task automatic test_branch_taken();
    exp_t e;
    set_bundle(1'b1, 2'b01, 1'b1);
    BranchTarget = 32'h40;
    tick();
    e = pop_exp();
    n_checks++; if (obs_now() !== e) begin n_fail++; $display("FAIL beq_capture got=%h exp=%h", obs_now(), e); end
    n_checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h40 || flush_upstream !== 1'b1) begin
      n_fail++; $display("FAIL beq_redirect got=%b/%h/%b exp=1/40/1", redirect, redirect_pc, flush_upstream); end
    for (int k = 0; k < SQC; k++) begin
      set_bundle(1'b1, 2'b01, 1'b1);
      tick();
      e = pop_exp();
      n_checks++; if (obs_now() !== e || mem_valid !== 1'b0) begin
        n_fail++; $display("FAIL squash_drop[%0d] got=%h exp=%h", k, obs_now(), e); end
      n_checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h40 || flush_upstream !== (k < SQC - 1)) begin
        n_fail++; $display("FAIL squash_seq[%0d] got=%b/%h/%b exp=0/40/%b", k, redirect, redirect_pc, flush_upstream, (k < SQC - 1)); end
    end
    set_bundle(1'b1, 2'b00, 1'b0);
    tick();
    e = pop_exp();
    n_checks++; if (obs_now() !== e || mem_valid !== 1'b1) begin n_fail++; $display("FAIL post_squash got=%h exp=%h", obs_now(), e); end
  endtask

  task automatic test_decode_table();
    logic [1:0]  op_t [7] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01};
    logic        z_t  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        v_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        tk_t [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] tgt;
    exp_t        e;
    for (int i = 0; i < 7; i++) begin
      set_bundle(v_t[i], op_t[i], z_t[i]);
      tgt = (op_t[i] == 2'b11) ? JumpRegisterTarget : BranchTarget;
      tick();
      e = pop_exp();
      n_checks++; if (obs_now() !== e) begin n_fail++; $display("FAIL dec_capture[%0d] got=%h exp=%h", i, obs_now(), e); end
      n_checks++; if (redirect !== tk_t[i] || flush_upstream !== tk_t[i]) begin
        n_fail++; $display("FAIL dec_taken[%0d] got=%b/%b exp=%b", i, redirect, flush_upstream, tk_t[i]); end
      if (tk_t[i]) begin
        n_checks++; if (redirect_pc !== tgt) begin n_fail++; $display("FAIL dec_target[%0d] got=%h exp=%h", i, redirect_pc, tgt); end
      end
      for (int k = 0; k < 10 && m_sq > 0; k++) begin
        set_bundle(1'b1, 2'b00, 1'b0);
        tick();
        e = pop_exp();
        n_checks++; if (obs_now() !== e) begin n_fail++; $display("FAIL dec_drain[%0d] got=%h exp=%h", i, obs_now(), e); end
      end
      n_checks++; if (flush_upstream !== 1'b0) begin n_fail++; $display("FAIL dec_idle[%0d] got=%b exp=0", i, flush_upstream); end
    end
  endtask

  task automatic test_stall();
    exp_t        e, cur;
    logic [31:0] tgt;
    int          hi, n;
    stall = 1'b0; flush = 1'b0;
    set_bundle(1'b1, 2'b00, 1'b0);
    tick();
    cur = pop_exp();
    n_checks++; if (obs_now() !== cur) begin n_fail++; $display("FAIL stall_pre got=%h exp=%h", obs_now(), cur); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_bundle(1'b1, 2'b01, 1'b1);
      tick();
      n_checks++; if (obs_now() !== cur || redirect !== 1'b0 || flush_upstream !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%h/%b/%b exp=%h/0/0", i, obs_now(), redirect, flush_upstream, cur); end
    end
    stall = 1'b0;
    tgt = BranchTarget;
    tick();
    cur = pop_exp();
    hi = flush_upstream ? 1 : 0;
    n_checks++; if (obs_now() !== cur || redirect !== 1'b1 || redirect_pc !== tgt) begin
      n_fail++; $display("FAIL stall_release got=%h/%b/%h exp=%h/1/%h", obs_now(), redirect, redirect_pc, cur, tgt); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_bundle(1'b1, 2'b00, 1'b0);
      tick();
      if (flush_upstream) hi++;
      n_checks++; if (obs_now() !== cur || flush_upstream !== 1'b1 || redirect !== 1'b0) begin
        n_fail++; $display("FAIL squash_freeze[%0d] got=%h/%b/%b exp=%h/1/0", i, obs_now(), flush_upstream, redirect, cur); end
    end
    stall = 1'b0;
    n = 0;
    while (flush_upstream === 1'b1 && n < 20) begin
      set_bundle(1'b1, 2'b00, 1'b0);
      tick();
      if (flush_upstream) hi++;
      e = pop_exp();
      n_checks++; if (obs_now() !== e) begin n_fail++; $display("FAIL freeze_drain[%0d] got=%h exp=%h", n, obs_now(), e); end
      n++;
    end
    n_checks++; if (hi != SQC + 3) begin n_fail++; $display("FAIL squash_length got=%0d exp=%0d", hi, SQC + 3); end
  endtask

  task automatic test_flush();
    exp_t e, cur;
    set_bundle(1'b1, 2'b00, 1'b0);
    memwrite = 1'b1;
    tick();
    cur = pop_exp();
    n_checks++; if (obs_now() !== cur || mem_memwrite !== 1'b1) begin n_fail++; $display("FAIL flush_pre got=%h exp=%h", obs_now(), cur); end
    flush = 1'b1; stall = 1'b1;
    set_bundle(1'b1, 2'b00, 1'b0);
    memwrite = 1'b1;
    tick();
    cur.valid = 1'b0; cur.rw = 1'b0; cur.mw = 1'b0; cur.mr = 1'b0;
    n_checks++; if (mem_valid !== 1'b0 || mem_memwrite !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall got=%b/%b exp=0/0", mem_valid, mem_memwrite); end
    n_checks++; if (obs_now() !== cur) begin n_fail++; $display("FAIL flush_hold got=%h exp=%h", obs_now(), cur); end
    stall = 1'b0;
    set_bundle(1'b1, 2'b01, 1'b1);
    tick();
    n_checks++; if (redirect !== 1'b0 || flush_upstream !== 1'b0 || mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_blocks_branch got=%b/%b/%b exp=0/0/0", redirect, flush_upstream, mem_valid); end
    flush = 1'b0;
    tick();
    e = pop_exp();
    n_checks++; if (obs_now() !== e || redirect !== 1'b1 || flush_upstream !== 1'b1) begin
      n_fail++; $display("FAIL flush_then_branch got=%h/%b exp=%h/1", obs_now(), redirect, e); end
    flush = 1'b1;
    set_bundle(1'b1, 2'b00, 1'b0);
    tick();
    n_checks++; if (flush_upstream !== (m_sq > 0) || mem_valid !== 1'b0 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL flush_in_squash got=%b/%b exp=%b/0", flush_upstream, mem_valid, (m_sq > 0)); end
    flush = 1'b0;
    for (int i = 0; i < SQC; i++) begin
      set_bundle(1'b1, 2'b00, 1'b0);
      tick();
      e = pop_exp();
      n_checks++; if (obs_now() !== e || flush_upstream !== (m_sq > 0)) begin
        n_fail++; $display("FAIL flush_recover[%0d] got=%h/%b exp=%h/%b", i, obs_now(), flush_upstream, e, (m_sq > 0)); end
    end
  endtask

  task automatic test_reset_mid_squash();
    exp_t e;
    set_bundle(1'b1, 2'b11, 1'b0);
    tick();
    e = pop_exp();
    n_checks++; if (flush_upstream !== 1'b1 || redirect !== 1'b1 || mem_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre got=%b/%b/%b exp=1/1/1", flush_upstream, redirect, mem_valid); end
    #2;
    Rst_n = 1'b0;
    #1;
    n_checks++; if (flush_upstream !== 1'b0 || redirect !== 1'b0 || mem_valid !== 1'b0 || mem_pc !== RPC) begin
      n_fail++; $display("FAIL rst_async got=%b/%b/%b/%h exp=0/0/0/%h", flush_upstream, redirect, mem_valid, mem_pc, RPC); end
    @(posedge Clk);
    #1;
    model_reset();
    Rst_n = 1'b1;
    set_bundle(1'b1, 2'b00, 1'b0);
    tick();
    e = pop_exp();
    n_checks++; if (obs_now() !== e || flush_upstream !== 1'b0) begin
      n_fail++; $display("FAIL rst_resume got=%h/%b exp=%h/0", obs_now(), flush_upstream, e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_branch_taken();
    test_decode_table();
    test_stall();
    test_flush();
    test_reset_mid_squash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Receiving end of the execute-phase output bundle; sits between the execute phase and the memory phase.
- Registers ALU result, store data, destination register, PC and control signals into the EX/MEM boundary, with stall and flush support.
- Resolves branch and jump-register redirection from the registered bundle and drives a multi-cycle upstream squash sequence.

Parameters:
- SQUASH_CYCLES, 2, cycles for which flush_upstream stays asserted after a redirect (1..7).
- RESET_PC, 32'h0000_0000, value loaded into pc_q on reset.

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute bundle holds a real instruction.
- ALU_result  in  32  execute ALU result.
- Zero  in  1  ALU zero flag.
- regdst  in  5  destination register number.
- reg_data2  in  32  store data.
- pc  in  32  instruction PC.
- BranchTarget  in  32  computed branch target.
- JumpRegisterTarget  in  32  jr target.
- regwrite, memwrite, memread  in  1 each  control signals.
- memtoreg  in  2  writeback select.
- decodeop  in  2  00 none, 01 beq (taken if Zero), 10 bne (taken if !Zero), 11 jr (always taken).
- stall  in  1  memory phase not ready; hold all registers.
- flush  in  1  external flush; insert bubble.
- mem_valid  out  1  registered valid.
- mem_alu_result, mem_store_data, mem_pc  out  32 each  registered data.
- mem_regdst  out  5  registered destination.
- mem_regwrite, mem_memwrite, mem_memread  out  1 each  registered controls, gated by valid.
- mem_memtoreg  out  2  registered writeback select.
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  target for the redirect.
- flush_upstream  out  1  squash IF/ID and ID/EX contents.

Behaviour:
- Reset (async, Rst_n=0):
  - All data outputs are 0, except mem_pc = RESET_PC.
  - mem_valid = 0, redirect = 0, flush_upstream = 0.
  - FSM returns to IDLE and the squash counter is 0.
- Capture priority: flush > stall > load.
  - flush: mem_valid <= 0; data registers are don't-care but must hold their old values.
  - stall: all registers hold.
  - Otherwise: load all fields; mem_valid <= ex_valid && !squashing.
- Control gating: mem_regwrite, mem_memwrite and mem_memread are ANDed with mem_valid at the output. An invalid slot never writes.
- Redirect evaluation:
  - Evaluated combinationally on the captured inputs at load time.
  - taken = ex_valid && !squashing && ((decodeop==01 && Zero) || (decodeop==10 && !Zero) || decodeop==11).
  - On a load with taken: redirect pulses high the next cycle for exactly 1 cycle.
  - redirect_pc is registered: BranchTarget for 01/10, JumpRegisterTarget for 11.
- FSM:
  - IDLE -> SQUASH on a registered taken; counter loads SQUASH_CYCLES.
  - In SQUASH, flush_upstream = 1 and the counter decrements each non-stalled cycle. The counter freezes under stall.
  - SQUASH -> IDLE when the counter reaches 1 and the cycle is not stalled.
  - squashing = (state == SQUASH). Bundles arriving during SQUASH load with valid = 0, so wrong-path instructions are dropped.
- Simultaneous events:
  - External flush during SQUASH: the FSM continues and the bubble is inserted.
  - A taken branch arriving with stall=1 is not captured until stall drops.
  - No new redirect is accepted while in SQUASH.
- Latency: 1 cycle from input to mem_* outputs; redirect appears 1 cycle after capture.
- Reset mid-SQUASH aborts the sequence immediately.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- Defined: adds outputs redirect_count[31:0] and bubble_count[31:0].
  - redirect_count increments on each redirect pulse.
  - bubble_count increments on each cycle where a load produced mem_valid=0.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_pkg:
  - decodeop encodings DEC_NONE/DEC_BEQ/DEC_BNE/DEC_JR.
  - memtoreg encodings.
  - FSM state typedef (IDLE, SQUASH).
- One natural sub-module: redirect_ctrl, holding the taken logic, the FSM and the squash counter.

Test Plan:
- Reset release with ex_valid=1, ALU_result=32'h1234, regdst=5'd8, regwrite=1 -> next cycle mem_alu_result=32'h1234, mem_regdst=8, mem_regwrite=1, mem_valid=1.
- decodeop=01, Zero=1, BranchTarget=32'h40 -> redirect=1 for one cycle with redirect_pc=32'h40; flush_upstream=1 for 2 cycles; the 2 following bundles have mem_valid=0.
- decodeop=10 with Zero=1 -> no redirect, flush_upstream stays 0.
- stall=1 held 3 cycles while inputs change -> outputs unchanged. If in SQUASH, the counter freezes and flush_upstream stays high 3 extra cycles.
- flush=1 together with stall=1 and a memwrite=1 bundle -> mem_valid=0, mem_memwrite=0.
- Rst_n asserted mid-SQUASH -> flush_upstream, redirect and mem_valid drop asynchronously; mem_pc=RESET_PC.
